uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Shares one UART transmit line among `NUM_REQ` byte-stream requesters. It combines a round-robin arbiter with a frame sequencer: it grants one requester at a time, latches that requester's word, and serialises it as start, data (LSB first), optional parity and 1 or 2 stop bits. Bit timing comes from a programmable clock divider. The block sits between on-chip producers (debug, log, console) and the pad-level `tx` line checked by the `uart_if` VIP.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥1)
- `MAX_DATA_WIDTH`, 8, widest data field supported (1..16)

Ports:
- `clk_i` in 1: clock
- `arst_ni` in 1: asynchronous reset, active-low
- `cfg_clk_div_i` in 16: bit period minus one, in clocks (bit period P = value+1)
- `cfg_data_bits_i` in 5: data bits D; 0 → 1, >`MAX_DATA_WIDTH` → `MAX_DATA_WIDTH`
- `cfg_parity_en_i` in 1: 1 = append parity bit
- `cfg_parity_odd_i` in 1: 1 = odd parity, 0 = even parity
- `cfg_stop2_i` in 1: 1 = two stop bits, 0 = one stop bit
- `req_data_i` in `NUM_REQ*MAX_DATA_WIDTH`: flattened words; requester i occupies slice i
- `req_valid_i` in `NUM_REQ`: word present
- `req_ready_o` out `NUM_REQ`: one-hot grant/accept
- `grant_id_o` out `$clog2(NUM_REQ)` (min 1): index of the last accepted requester
- `busy_o` out 1: frame in progress
- `tx_o` out 1: serial line, idle high

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx_o`=1.
  - If any `req_valid_i` is set, select the winner by round-robin, searching upward from `grant_id_o`+1 with wrap.
  - Assert `req_ready_o[winner]` combinationally in the same cycle. Only IDLE drives ready; it may depend on `req_valid_i`.
  - Handshake = valid & ready. On the handshake:
    - latch the word, D, parity enable/type, stop count and P;
    - set `grant_id_o`=winner;
    - go to START.
- **Requester rule:** valid is held with stable data until ready. Dropping valid before grant is legal; that requester is simply skipped.
- **START:** `tx_o`=0 for P cycles → DATA.
- **DATA**
  - `tx_o` = latched word bit k, for k=0..D-1, P cycles each.
  - Bits ≥D are ignored.
  - After the last bit → PARITY if enabled, else STOP.
- **PARITY:** `tx_o` = XOR of the D data bits, inverted when odd; P cycles → STOP.
- **STOP:** `tx_o`=1 for P cycles (or 2P with `cfg_stop2_i`) → IDLE.
- **Counters**
  - The bit-phase counter counts 0..P-1 and wraps.
  - The bit index is 0..D-1.
  - The stop counter is 0..1.
  - P=1 (div=0) is legal: one clock per bit.
- `busy_o` = (state ≠ IDLE).
- **Config changes:** changes to `cfg_*` while busy have no effect on the current frame. They take effect at the next handshake.

## Timing
- **Reset values:** `tx_o`=1, `req_ready_o`=0, `busy_o`=0, `grant_id_o`=NUM_REQ-1 (so requester 0 wins first), state IDLE.
- **Frame timing**
  - Handshake at cycle T → `tx_o` falls at T+1.
  - Frame length F = P·(1+D+par+stops) cycles, covering T+1..T+F.
  - Back at IDLE at T+F+1.
- **Back-to-back:** the earliest next handshake is T+F+1, so the next start bit is at T+F+2. This adds one idle clock of extra stop time per frame, inherent and permitted.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.
- **Single requester:** a single continuously valid requester is granted every frame.
- **Reset mid-frame:** asynchronous. `tx_o` returns to 1 immediately, the frame is abandoned, and the latched word is discarded. The requester is not re-served unless it re-asserts valid.
- **Simultaneous events:** a valid rising in the same cycle as the FSM enters IDLE is not seen until that IDLE cycle. There is no lookahead.

## Test plan
- **Single 8N1 frame:** div=4 (P=5, 20 Mbaud at 100 MHz), D=8, no parity, requester 0 sends 0xA5 → `uart_if` VIP set to 20000000/8/0/1 receives 0xA5. `tx_o` shows start + 1,0,1,0,0,1,0,1 + stop, each 5 cycles. `busy_o` is high for 50 cycles.
- **Round-robin:** all 4 requesters valid with 0x10..0x13, D=8, div=0 → `grant_id_o` sequence 0,1,2,3; VIP receives 0x10,0x11,0x12,0x13. Each `req_ready_o` is a single-cycle pulse, one-hot.
- **Parity/stop/width:** D=7, odd parity, 2 stop bits, data 0x7F → parity bit 0, frame = 11 bit periods. Then D=4 even parity with data 0xFE → only 0xE is sent, parity bit 1.
- **Config change mid-frame:** change div 4→9 and D 8→5 during DATA → the current frame keeps P=5 and D=8. The next frame uses P=10 and D=5.
- **Reset mid-frame:** assert `arst_ni` low in bit 3 of DATA → `tx_o`=1 immediately and all outputs return to reset values. After release with requesters 2 and 3 valid, requester 2 is granted first.
- **Valid withdrawal:** requester 1 drops valid while requester 0 is being served; requester 2 is valid → the next grant goes to requester 2. No frame is sent for requester 1.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter feeding a programmable UART frame serialiser
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int MAX_DATA_WIDTH = 8,
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk_i,
  input  logic                              arst_ni,
  input  logic [15:0]                       cfg_clk_div_i,
  input  logic [4:0]                        cfg_data_bits_i,
  input  logic                              cfg_parity_en_i,
  input  logic                              cfg_parity_odd_i,
  input  logic                              cfg_stop2_i,
  input  logic [NUM_REQ*MAX_DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [GW-1:0]                     grant_id_o,
  output logic                              busy_o,
  output logic                              tx_o
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0] state;
  logic [15:0] phase, div;
  logic [3:0] bit_idx;
  logic [4:0] d_lat, d_eff;
  logic stop_cnt, par_en, stop2, par_bit, found, bit_end, last_bit, word_bit;
  logic [MAX_DATA_WIDTH-1:0] word, win_word, mask;
  logic [GW-1:0] winner, idx;
  always_comb begin
    winner = grant_id_o;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(grant_id_o) + k) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        winner = idx;
        found = 1'b1;
      end
    end
  end
  assign d_eff = cfg_data_bits_i == 5'd0 ? 5'd1 :
                 cfg_data_bits_i > 5'(MAX_DATA_WIDTH) ? 5'(MAX_DATA_WIDTH) : cfg_data_bits_i;
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) mask[i] = i < int'(d_eff);
  end
  // Bits above the configured width are cleared so parity and shifting only see the D data bits
  assign win_word = MAX_DATA_WIDTH'(req_data_i >> (int'(winner) * MAX_DATA_WIDTH)) & mask;
  assign word_bit = |(word & (MAX_DATA_WIDTH'(1) << bit_idx));
  assign bit_end = phase == div;
  assign last_bit = {1'b0, bit_idx} == d_lat - 5'd1;
  assign busy_o = state != IDLE;
  assign req_ready_o = (arst_ni && state == IDLE && found) ? NUM_REQ'(1) << winner : '0;
  assign tx_o = state == START ? 1'b0 : state == DATA ? word_bit : state == PARITY ? par_bit : 1'b1;
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state <= IDLE;
      phase <= '0;
      bit_idx <= '0;
      stop_cnt <= 1'b0;
      grant_id_o <= GW'(NUM_REQ - 1);
      word <= '0;
      div <= '0;
      d_lat <= 5'd1;
      par_en <= 1'b0;
      stop2 <= 1'b0;
      par_bit <= 1'b0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= START;
        phase <= '0;
        grant_id_o <= winner;
        word <= win_word;
        div <= cfg_clk_div_i;
        d_lat <= d_eff;
        par_en <= cfg_parity_en_i;
        stop2 <= cfg_stop2_i;
        par_bit <= ^win_word ^ cfg_parity_odd_i;
      end
    end else begin
      phase <= bit_end ? '0 : phase + 16'd1;
      if (bit_end) begin
        bit_idx <= state == DATA && !last_bit ? bit_idx + 4'd1 : '0;
        stop_cnt <= state == STOP && stop2 && !stop_cnt;
        case (state)
          START:   state <= DATA;
          DATA:    state <= last_bit ? (par_en ? PARITY : STOP) : DATA;
          PARITY:  state <= STOP;
          default: state <= stop2 && !stop_cnt ? STOP : IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: vector table plus a frame scoreboard decoding tx_o bit by bit
module tb_uart_tx_sched;
  logic clk_i = 1'b0, arst_ni = 1'b1;
  logic [15:0] cfg_clk_div_i;
  logic [4:0] cfg_data_bits_i;
  logic cfg_parity_en_i, cfg_parity_odd_i, cfg_stop2_i;
  logic [31:0] req_data_i;
  logic [3:0] req_valid_i, req_ready_o;
  logic [1:0] grant_id_o;
  logic busy_o, tx_o;
  int checks = 0, errors = 0;
  logic abort = 1'b0;
  logic [3:0] pend = '0, prev_ready = '0;
  typedef struct { int p; int d; logic pe; logic po; logic s2; logic [7:0] data; int id; } frame_t;
  typedef struct { logic [15:0] div; logic [4:0] d; logic pe; logic po; logic s2; int id; logic [7:0] data; } vec_t;
  frame_t exp_q[$];
  vec_t vecs[6];
  always #5 clk_i = ~clk_i;
  uart_tx_sched dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .cfg_clk_div_i(cfg_clk_div_i), .cfg_data_bits_i(cfg_data_bits_i),
    .cfg_parity_en_i(cfg_parity_en_i), .cfg_parity_odd_i(cfg_parity_odd_i), .cfg_stop2_i(cfg_stop2_i),
    .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .grant_id_o(grant_id_o), .busy_o(busy_o), .tx_o(tx_o)
  );
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask
  function automatic int deff(input logic [4:0] d);
    return d == 5'd0 ? 1 : (d > 5'd8 ? 8 : int'(d));
  endfunction
  function automatic void push(input int id, input logic [7:0] data);
    frame_t e;
    e.p = int'(cfg_clk_div_i) + 1;
    e.d = deff(cfg_data_bits_i);
    e.pe = cfg_parity_en_i;
    e.po = cfg_parity_odd_i;
    e.s2 = cfg_stop2_i;
    e.data = data;
    e.id = id;
    exp_q.push_back(e);
  endfunction
  task automatic cfg(input logic [15:0] div, input logic [4:0] d, input logic pe, input logic po, input logic s2);
    cfg_clk_div_i = div;
    cfg_data_bits_i = d;
    cfg_parity_en_i = pe;
    cfg_parity_odd_i = po;
    cfg_stop2_i = s2;
  endtask
  task automatic set_req(input int id, input logic [7:0] data);
    req_data_i[id*8 +: 8] = data;
    req_valid_i[id] = 1'b1;
  endtask
  // A requester drops valid on the negedge after its handshake edge
  task automatic step();
    #1;
    pend = arst_ni ? (req_ready_o & req_valid_i) : '0;
    @(negedge clk_i);
    req_valid_i = req_valid_i & ~pend;
  endtask
  task automatic wait_busy();
    int n = 0;
    while (!busy_o && n < 20) begin
      step();
      n++;
    end
    chk("busy_rise", int'(busy_o), 1);
  endtask
  task automatic wait_all(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o || req_valid_i != 0) && n < 5000) begin
      step();
      n++;
    end
    chk(name, int'(n < 5000), 1);
  endtask
  task automatic reset_check(input string tag);
    chk({tag, "_tx"}, int'(tx_o), 1);
    chk({tag, "_ready"}, int'(req_ready_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_grant"}, int'(grant_id_o), 3);
  endtask
  task automatic run_vec(input vec_t v, input int n);
    int f, cnt;
    cfg(v.div, v.d, v.pe, v.po, v.s2);
    set_req(v.id, v.data);
    push(v.id, v.data);
    f = (int'(v.div) + 1) * (1 + deff(v.d) + int'(v.pe) + (v.s2 ? 2 : 1));
    wait_busy();
    cnt = 0;
    while (busy_o && cnt < 5000) begin
      step();
      cnt++;
    end
    chk($sformatf("vec%0d_frame_len", n), cnt, f);
    chk($sformatf("vec%0d_grant", n), int'(grant_id_o), v.id);
    chk($sformatf("vec%0d_queue", n), exp_q.size(), 0);
  endtask
  initial begin : monitor
    frame_t e;
    logic [31:0] fb;
    int nb, got;
    logic par;
    bit aborted;
    forever begin
      @(negedge clk_i);
      if (arst_ni && tx_o === 1'b0 && !abort) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 0, 1);
          while (tx_o === 1'b0) @(negedge clk_i);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("frame_id%0d_grant", e.id), int'(grant_id_o), e.id);
          fb = '1;
          fb[0] = 1'b0;
          par = e.po;
          for (int k = 0; k < e.d; k++) begin
            fb[1+k] = e.data[k];
            par = par ^ e.data[k];
          end
          nb = 1 + e.d;
          if (e.pe) begin
            fb[nb] = par;
            nb++;
          end
          nb += e.s2 ? 2 : 1;
          aborted = 1'b0;
          for (int b = 0; b < nb && !aborted; b++) begin
            got = int'(fb[b]);
            for (int c = 0; c < e.p && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk_i);
              if (abort) aborted = 1'b1;
              else if (tx_o !== fb[b]) got = int'(tx_o);
            end
            if (!aborted) chk($sformatf("frame_id%0d_bit%0d", e.id, b), got, int'(fb[b]));
          end
          if (!aborted) begin
            @(negedge clk_i);
            chk($sformatf("frame_id%0d_idle_busy", e.id), int'(busy_o), 0);
            chk($sformatf("frame_id%0d_idle_tx", e.id), int'(tx_o), 1);
          end
        end
      end
    end
  end
  initial begin : ready_mon
    forever begin
      @(negedge clk_i);
      #3;
      if (req_ready_o != '0) begin
        checks++;
        if (!$onehot(req_ready_o) || (req_ready_o & prev_ready) != '0) begin
          errors++;
          $display("FAIL ready_pulse: got %b after %b, expected one-hot single-cycle", req_ready_o, prev_ready);
        end
      end
      prev_ready = req_ready_o;
    end
  end
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
  initial begin
    vecs[0] = '{16'd4, 5'd8,  1'b0, 1'b0, 1'b0, 0, 8'hA5};
    vecs[1] = '{16'd1, 5'd7,  1'b1, 1'b1, 1'b1, 1, 8'h7F};
    vecs[2] = '{16'd0, 5'd4,  1'b1, 1'b0, 1'b0, 2, 8'hFE};
    vecs[3] = '{16'd2, 5'd0,  1'b0, 1'b0, 1'b0, 3, 8'h01};
    vecs[4] = '{16'd0, 5'd20, 1'b1, 1'b1, 1'b1, 0, 8'h3C};
    vecs[5] = '{16'd0, 5'd8,  1'b0, 1'b0, 1'b0, 1, 8'h00};
    cfg(16'd0, 5'd8, 1'b0, 1'b0, 1'b0);
    req_data_i = '0;
    req_valid_i = '0;
    #1 arst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_check("por");
    arst_ni = 1'b1;
    step();
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    cfg(16'd4, 5'd8, 1'b0, 1'b0, 1'b0);
    set_req(2, 8'h5A);
    push(2, 8'h5A);
    wait_busy();
    repeat (15) step();
    cfg(16'd9, 5'd5, 1'b0, 1'b0, 1'b0);
    set_req(3, 8'h1B);
    push(3, 8'h1B);
    wait_all("cfg_change_drain");
    #2 arst_ni = 1'b0;
    step();
    reset_check("rr_rst");
    arst_ni = 1'b1;
    cfg(16'd0, 5'd8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_req(i, 8'h10 + 8'(i));
      push(i, 8'h10 + 8'(i));
    end
    wait_all("rr_drain");
    cfg(16'd1, 5'd8, 1'b0, 1'b0, 1'b0);
    set_req(0, 8'h61);
    push(0, 8'h61);
    wait_busy();
    set_req(1, 8'h62);
    set_req(2, 8'h63);
    repeat (5) step();
    req_valid_i[1] = 1'b0;
    push(2, 8'h63);
    wait_all("withdraw_drain");
    chk("withdraw_grant", int'(grant_id_o), 2);
    cfg(16'd4, 5'd8, 1'b0, 1'b0, 1'b0);
    set_req(1, 8'h33);
    push(1, 8'h33);
    wait_busy();
    repeat (21) step();
    chk("pre_reset_grant", int'(grant_id_o), 1);
    #2;
    abort = 1'b1;
    arst_ni = 1'b0;
    set_req(2, 8'h22);
    set_req(3, 8'h44);
    #1 reset_check("mid_rst");
    step();
    step();
    abort = 1'b0;
    arst_ni = 1'b1;
    push(2, 8'h22);
    push(3, 8'h44);
    wait_all("post_reset_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
